// File: rtl/json_cmd_pkg.sv
// Shared types and command codes for the JSON command path (scheduler and sender).
package json_cmd_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} sched_state_t;

  localparam logic [3:0] CMD_STOP      = 4'd0;
  localparam logic [3:0] CMD_FWD       = 4'd1;
  localparam logic [3:0] CMD_LEFT      = 4'd2;
  localparam logic [3:0] CMD_RIGHT     = 4'd3;
  localparam logic [3:0] CMD_HEARTBEAT = 4'd4;

  // Width of a counter that must hold the larger of two clock budgets.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/cmd_arb_pick.sv
// Combinational picker: requester 0 wins outright, the rest are searched
// round-robin from rr_ptr upward, wrapping back to 1.
module cmd_arb_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               pick_valid,
  output logic [IDX_W-1:0]   pick_idx
);

  int cand;

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    if (req[0]) begin
      pick_valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        // maps rr_ptr+k onto the range 1..NUM_REQ-1
        cand = (int'(rr_ptr) + NUM_REQ - 2 + k) % (NUM_REQ - 1) + 1;
        if (!pick_valid && req[cand]) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/json_cmd_scheduler.sv
// Shares one JSON command sender among NUM_REQ requesters: fixed priority for
// the stop path (0), round-robin for the rest, with completion timeout and gap.
module json_cmd_scheduler
  import json_cmd_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int CMD_W        = 4,
  parameter int GAP_CLKS     = 50_000,
  parameter int TIMEOUT_CLKS = 250_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       snd_valid,
  output logic [CMD_W-1:0]           snd_cmd,
  input  logic                       snd_ready,
  input  logic                       snd_done,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(GAP_CLKS, TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CLKS - 1);
  // A zero gap still spends one cycle in GAP, same as a gap of one.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  sched_state_t      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  owner_q;
  logic [IDX_W-1:0]  rr_q;
  logic [CMD_W-1:0]  cmd_q;
  logic [NUM_REQ-1:0] done_q;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

  function automatic logic [IDX_W-1:0] next_rr(input logic [IDX_W-1:0] idx);
    if (int'(idx) >= NUM_REQ - 1) return IDX_W'(1);
    return idx + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  cmd_arb_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req        (req),
    .rr_ptr     (rr_q),
    .pick_valid (pick_valid),
    .pick_idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      rr_q    <= IDX_W'(1);
      cmd_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_valid) begin
            owner_q <= pick_idx;
            cmd_q   <= req_cmd[int'(pick_idx)*CMD_W +: CMD_W];
            if (pick_idx != '0) rr_q <= next_rr(pick_idx);
          end
        end
        ISSUE: begin
          if (snd_ready) cnt_q <= '0;
        end
        WAIT_DONE: begin
          if (snd_done) begin
            done_q <= onehot(owner_q);
            cnt_q  <= '0;
          end else if (cnt_q == TO_LAST) begin
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) cnt_q <= '0;
          else                   cnt_q <= cnt_q + CNT_W'(1);
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (pick_valid) state_d = ISSUE;
      ISSUE:     if (snd_ready) state_d = WAIT_DONE;
      WAIT_DONE: if (snd_done || cnt_q == TO_LAST) state_d = GAP;
      GAP:       if (cnt_q == GAP_LAST) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign snd_valid   = (state_q == ISSUE);
  assign snd_cmd     = cmd_q;
  assign gnt         = (state_q == ISSUE && snd_ready) ? onehot(owner_q) : '0;
  assign done        = done_q;
  assign timeout_err = (state_q == WAIT_DONE) && (cnt_q == TO_LAST) && !snd_done;
  assign busy        = (state_q != IDLE);
  assign owner       = owner_q;

endmodule
